// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the pipeline memory stage and
// the loader/debug port, and routes each one-cycle-late response to its issuer.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  localparam int CW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  // pipeline requester
  input  logic          p_valid,
  input  logic          p_read_write,
  input  logic [31:0]   p_address,
  input  logic [31:0]   p_data_in,
  input  logic          p_is_unsigned,
  input  logic [1:0]    p_access_size,
  output logic          p_stall,
  output logic          p_rvalid,
  output logic [31:0]   p_rdata,
  output logic          p_fault,
  // loader / debug requester
  input  logic          l_req,
  input  logic          l_read_write,
  input  logic [31:0]   l_address,
  input  logic [31:0]   l_data_in,
  input  logic          l_is_unsigned,
  input  logic [1:0]    l_access_size,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_fault,
  // memory wrapper
  output logic          m_read_write,
  output logic [31:0]   m_address,
  output logic [31:0]   m_data_in,
  output logic          m_is_unsigned,
  output logic [1:0]    m_access_size,
  input  logic [31:0]   m_data_out,
  // observability of the starvation counter
  output logic [CW-1:0] dbg_starve_cnt
);

  // Handshakes: the pipeline offers with p_valid and is accepted in any cycle
  // where p_stall=0; the loader holds l_req with stable fields until l_gnt=1.
  // Acceptance happens in the same cycle; load data and faults return one
  // cycle later on the owner's rvalid/fault, stores return nothing.

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          forced;
  logic          p_win;
  logic          l_win;
  logic          any_win;

  logic          w_read_write;
  logic [31:0]   w_address;
  logic [31:0]   w_data_in;
  logic          w_is_unsigned;
  logic [1:0]    w_access_size;
  logic          w_misaligned;
  logic          w_fault;
  logic          w_issue;

  logic          rsp_rd;
  logic          rsp_flt;
  logic          rsp_own;

  // Grant: pipeline has priority unless the loader has starved up to the limit.
  always_comb begin
    forced  = l_req & (starve_cnt == LIMIT);
    l_win   = l_req & (forced | ~p_valid);
    p_win   = p_valid & ~l_win;
    any_win = p_win | l_win;
    p_stall = p_valid & ~p_win;
    l_gnt   = l_win;
  end

  always_comb begin
    if (l_win) begin
      w_read_write  = l_read_write;
      w_address     = l_address;
      w_data_in     = l_data_in;
      w_is_unsigned = l_is_unsigned;
      w_access_size = l_access_size;
    end else begin
      w_read_write  = p_read_write;
      w_address     = p_address;
      w_data_in     = p_data_in;
      w_is_unsigned = p_is_unsigned;
      w_access_size = p_access_size;
    end
  end

  always_comb begin
    unique case (w_access_size)
      2'd0:    w_misaligned = 1'b0;
      2'd1:    w_misaligned = w_address[0];
      2'd2:    w_misaligned = |w_address[1:0];
      default: w_misaligned = 1'b1;
    endcase
    w_fault = any_win & w_misaligned;
    w_issue = any_win & ~w_misaligned;
  end

  // A faulting or absent winner leaves the memory doing a harmless word load at 0.
  always_comb begin
    m_read_write  = 1'b0;
    m_address     = 32'd0;
    m_data_in     = 32'd0;
    m_is_unsigned = 1'b0;
    m_access_size = 2'd2;
    if (w_issue) begin
      m_read_write  = w_read_write;
      m_address     = w_address;
      m_data_in     = w_data_in;
      m_is_unsigned = w_is_unsigned;
      m_access_size = w_access_size;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!l_req || l_win) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Response tracking mirrors the memory's one-cycle read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rd  <= 1'b0;
      rsp_flt <= 1'b0;
      rsp_own <= 1'b0;
    end else begin
      rsp_rd  <= w_issue & ~w_read_write;
      rsp_flt <= w_fault;
      rsp_own <= l_win;
    end
  end

  always_comb begin
    p_rvalid       = rsp_rd & ~rsp_own;
    l_rvalid       = rsp_rd & rsp_own;
    p_fault        = rsp_flt & ~rsp_own;
    l_fault        = rsp_flt & rsp_own;
    p_rdata        = m_data_out;
    l_rdata        = m_data_out;
    dbg_starve_cnt = starve_cnt;
  end

endmodule
